// File: rtl/debounce_sync.sv
// debounce_sync: synchronises a raw, bouncing board input and turns it into a
// clean level with one-cycle rise/fall pulses. A saturating glitch counter
// records how many pending transitions were abandoned because the input
// reversed before it had been stable long enough.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_LOW        | level_out = 0, input stable low, counter idle at 0
// S_RISE_WAIT  | input seen high, counting stable-high cycles toward a rise
// S_HIGH       | level_out = 1, input stable high, counter idle at 0
// S_FALL_WAIT  | input seen low, counting stable-low cycles toward a fall
//
// Latency: if raw_in changes just after edge E0 and then holds, level_out
// changes at edge E0 + SYNC_STAGES + DEBOUNCE_CYCLES + 1. One edge is spent
// capturing the change in the first sync flop, SYNC_STAGES-1 more edges
// carry it to s, one edge moves the FSM into the WAIT state, and
// DEBOUNCE_CYCLES further edges complete the count.

module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_in,
  output logic       level_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_cnt
);

  // Terminal count: the WAIT state completes on the edge that observes this.
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       GLITCH_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  // Shift raw_in into the chain; bit 0 is the metastability-exposed flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Synchroniser flops, cleared by reset so the FSM starts from a known low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Only the last stage is safe to use; raw_in never reaches the FSM directly.
  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic [7:0]       glitch_q, glitch_d;
  logic [7:0]       glitch_inc;

  // Saturating increment used when a pending transition is abandoned.
  always_comb begin
    glitch_inc = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + 8'd1;
  end

  // Next-state logic. Pulses default low so they last exactly one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    case (state_q)
      S_LOW: begin
        cnt_d = '0;
        if (s) begin
          state_d = S_RISE_WAIT;
        end
      end
      S_RISE_WAIT: begin
        if (!s) begin
          // Bounce: abandon the rise; the next attempt restarts from zero.
          state_d  = S_LOW;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        cnt_d = '0;
        if (!s) begin
          state_d = S_FALL_WAIT;
        end
      end
      S_FALL_WAIT: begin
        if (s) begin
          state_d  = S_HIGH;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // FSM state, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = glitch_q;

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rise_q && fall_q));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_LAST);

  a_cnt_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_LOW || state_q == S_HIGH) |-> (cnt_q == '0));

  a_level_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_HIGH) |-> level_q);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a SYNC_STAGES=3,
// DEBOUNCE_CYCLES=2 instance. Expected latencies and glitch counts are
// queued when stimulus is applied and checked when the level changes.

module tb_debounce_sync;

  logic       clk;
  logic       rst_n;
  logic       raw_in;
  logic       level_out, rise_pulse, fall_pulse;
  logic [7:0] glitch_cnt;

  logic       raw_b;
  logic       level_b, rise_b, fall_b;
  logic [7:0] glitch_b;

  int total = 0;
  int bad   = 0;
  int exp_glitch = 0;

  typedef struct {
    int         lat;
    logic [7:0] glitch;
  } exp_t;

  exp_t exp_q[$];

  debounce_sync dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt)
  );

  debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_b),
    .level_out  (level_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .glitch_cnt (glitch_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses must never overlap and must agree with the new level.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (rise_pulse && fall_pulse) begin
        bad++;
        $display("FAIL pulse_overlap: rise=%0b fall=%0b required not both 1", rise_pulse, fall_pulse);
      end
      total++;
      if ((rise_pulse && !level_out) || (fall_pulse && level_out)) begin
        bad++;
        $display("FAIL pulse_level: rise=%0b fall=%0b level=%0b", rise_pulse, fall_pulse, level_out);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Count edges (sampled 1 ns after each) until level_out reaches target.
  task automatic wait_level(input logic target, output int n,
                            output bit early_rise, output bit early_fall);
    n = 0;
    early_rise = 0;
    early_fall = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (level_out === target) break;
      if (rise_pulse) early_rise = 1;
      if (fall_pulse) early_fall = 1;
    end
    if (level_out !== target) n = 999;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n  = 1'b0;
    raw_in = 1'b0;
    raw_b  = 1'b0;
    #2;
    exp_q.push_back('{lat: 0, glitch: 8'd0});
    e = exp_q.pop_front();
    total++;
    if (level_out !== 1'b0) begin bad++; $display("FAIL reset_level: got %0b want 0", level_out); end
    total++;
    if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
      bad++; $display("FAIL reset_pulses: got rise=%0b fall=%0b want 0 0", rise_pulse, fall_pulse);
    end
    total++;
    if (glitch_cnt !== e.glitch) begin bad++; $display("FAIL reset_glitch: got %0d want %0d", glitch_cnt, e.glitch); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || level_out !== 1'b0) begin
      bad++; $display("FAIL release_quiet: rise=%0b fall=%0b level=%0b want 0 0 0", rise_pulse, fall_pulse, level_out);
    end
  endtask

  task automatic test_clean_rise();
    int n; bit er, ef; exp_t e;
    @(posedge clk); #1;
    raw_in = 1'b1;
    exp_q.push_back('{lat: 19, glitch: 8'(exp_glitch)});
    wait_level(1'b1, n, er, ef);
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat) begin bad++; $display("FAIL rise_latency: got %0d edges want %0d", n, e.lat); end
    total++;
    if (rise_pulse !== 1'b1 || er) begin bad++; $display("FAIL rise_pulse: at change %0b early %0b want 1 0", rise_pulse, er); end
    total++;
    if (glitch_cnt !== e.glitch) begin bad++; $display("FAIL rise_glitch: got %0d want %0d", glitch_cnt, e.glitch); end
    @(posedge clk); #1;
    total++;
    if (rise_pulse !== 1'b0 || level_out !== 1'b1) begin
      bad++; $display("FAIL rise_pulse_width: rise=%0b level=%0b want 0 1", rise_pulse, level_out);
    end
  endtask

  task automatic test_short_glitch_high();
    bit any_rise, any_fall, dropped; exp_t e;
    any_rise = 0; any_fall = 0; dropped = 0;
    @(posedge clk); #1;
    raw_in = 1'b0;
    exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
    exp_q.push_back('{lat: 0, glitch: 8'(exp_glitch)});
    for (int i = 0; i < 35; i++) begin
      if (i == 5) raw_in = 1'b1;
      @(posedge clk); #1;
      if (rise_pulse) any_rise = 1;
      if (fall_pulse) any_fall = 1;
      if (!level_out) dropped = 1;
    end
    e = exp_q.pop_front();
    total++;
    if (dropped || any_rise || any_fall) begin
      bad++; $display("FAIL glitch_high_quiet: dropped=%0b rise=%0b fall=%0b want 0 0 0", dropped, any_rise, any_fall);
    end
    total++;
    if (glitch_cnt !== e.glitch) begin bad++; $display("FAIL glitch_high_count: got %0d want %0d", glitch_cnt, e.glitch); end
  endtask

  task automatic test_clean_fall();
    int n; bit er, ef; exp_t e;
    @(posedge clk); #1;
    raw_in = 1'b0;
    exp_q.push_back('{lat: 19, glitch: 8'(exp_glitch)});
    wait_level(1'b0, n, er, ef);
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat) begin bad++; $display("FAIL fall_latency: got %0d edges want %0d", n, e.lat); end
    total++;
    if (fall_pulse !== 1'b1 || rise_pulse !== 1'b0 || er || ef) begin
      bad++; $display("FAIL fall_pulse: fall=%0b rise=%0b early_r=%0b early_f=%0b want 1 0 0 0", fall_pulse, rise_pulse, er, ef);
    end
    @(posedge clk); #1;
    total++;
    if (fall_pulse !== 1'b0 || level_out !== 1'b0 || glitch_cnt !== e.glitch) begin
      bad++; $display("FAIL fall_after: fall=%0b level=%0b glitch=%0d want 0 0 %0d", fall_pulse, level_out, glitch_cnt, e.glitch);
    end
  endtask

  task automatic test_bounce_rise();
    int n; bit er, ef; exp_t e;
    // 1,0,1,0,1,0 in 3-cycle segments: three aborted rises.
    for (int seg = 0; seg < 6; seg++) begin
      @(posedge clk); #1;
      raw_in = (seg % 2 == 0);
      repeat (2) @(posedge clk);
    end
    exp_glitch = (exp_glitch + 3 > 255) ? 255 : exp_glitch + 3;
    @(posedge clk); #1;
    raw_in = 1'b1;
    exp_q.push_back('{lat: 19, glitch: 8'(exp_glitch)});
    wait_level(1'b1, n, er, ef);
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat) begin bad++; $display("FAIL bounce_latency: got %0d edges want %0d", n, e.lat); end
    total++;
    if (glitch_cnt !== e.glitch) begin bad++; $display("FAIL bounce_glitch: got %0d want %0d", glitch_cnt, e.glitch); end
    total++;
    if (rise_pulse !== 1'b1) begin bad++; $display("FAIL bounce_rise_pulse: got %0b want 1", rise_pulse); end
  endtask

  task automatic test_reset_in_high();
    int n; bit er, ef; exp_t e;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_glitch = 0;
    total++;
    if (level_out !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || glitch_cnt !== 8'd0) begin
      bad++; $display("FAIL async_reset_high: level=%0b rise=%0b fall=%0b glitch=%0d want all 0",
                      level_out, rise_pulse, fall_pulse, glitch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back('{lat: 19, glitch: 8'd0});
    wait_level(1'b1, n, er, ef);
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat || er || ef) begin
      bad++; $display("FAIL post_reset_rise: got %0d edges early_r=%0b early_f=%0b want %0d 0 0", n, er, ef, e.lat);
    end
    total++;
    if (rise_pulse !== 1'b1 || glitch_cnt !== e.glitch) begin
      bad++; $display("FAIL post_reset_pulse: rise=%0b glitch=%0d want 1 %0d", rise_pulse, glitch_cnt, e.glitch);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n; bit er, ef; exp_t e;
    @(posedge clk); #1;
    raw_in = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (level_out !== 1'b0 || fall_pulse !== 1'b0) begin
      bad++; $display("FAIL async_reset_wait: level=%0b fall=%0b want 0 0", level_out, fall_pulse);
    end
    raw_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back('{lat: 19, glitch: 8'(exp_glitch)});
    wait_level(1'b1, n, er, ef);
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat || rise_pulse !== 1'b1 || ef) begin
      bad++; $display("FAIL wait_reset_rise: got %0d edges rise=%0b early_f=%0b want %0d 1 0", n, rise_pulse, ef, e.lat);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1; raw_in = 1'b1;
      repeat (2) @(posedge clk);
      @(posedge clk); #1; raw_in = 1'b0;
      repeat (2) @(posedge clk);
    end
    exp_glitch = (exp_glitch + 300 > 255) ? 255 : exp_glitch + 300;
    exp_q.push_back('{lat: 0, glitch: 8'(exp_glitch)});
    repeat (5) @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (glitch_cnt !== e.glitch) begin bad++; $display("FAIL sat_value: got %0d want %0d", glitch_cnt, e.glitch); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; raw_in = 1'b1;
      repeat (2) @(posedge clk);
      @(posedge clk); #1; raw_in = 1'b0;
      repeat (2) @(posedge clk);
    end
    exp_q.push_back('{lat: 0, glitch: 8'd255});
    repeat (5) @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (glitch_cnt !== e.glitch || level_out !== 1'b0) begin
      bad++; $display("FAIL sat_hold: glitch=%0d level=%0b want %0d 0", glitch_cnt, level_out, e.glitch);
    end
  endtask

  task automatic test_params();
    int n; exp_t e;
    @(posedge clk); #1;
    raw_b = 1'b1;
    exp_q.push_back('{lat: 6, glitch: 8'd0});
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1; n++;
      if (level_b) break;
    end
    if (!level_b) n = 999;
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat || rise_b !== 1'b1) begin
      bad++; $display("FAIL param_rise: got %0d edges rise=%0b want %0d 1", n, rise_b, e.lat);
    end
    @(posedge clk); #1;
    raw_b = 1'b0;
    exp_q.push_back('{lat: 6, glitch: 8'd0});
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1; n++;
      if (!level_b) break;
    end
    if (level_b) n = 999;
    e = exp_q.pop_front();
    total++;
    if (n !== e.lat || fall_b !== 1'b1 || glitch_b !== e.glitch) begin
      bad++; $display("FAIL param_fall: got %0d edges fall=%0b glitch=%0d want %0d 1 %0d", n, fall_b, glitch_b, e.lat, e.glitch);
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_short_glitch_high();
    test_clean_fall();
    test_bounce_rise();
    test_reset_in_high();
    test_reset_mid_wait();
    test_clean_fall();
    test_saturation();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
